// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/trace readers.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mips_dbg_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int REG_N  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Output beat stream of the register dump: index/data pair with valid/ready.
// Latency: none, wiring only.
// Backpressure: the slave holds out_ready low to stall the master.
interface regfile_dump_if import mips_dbg_pkg::*; #(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);

endinterface

// File: rtl/regfile_dump.sv
// Walks an inclusive wrap-around register index range and streams each value out.
// Latency: first beat valid 2 cycles after start; 1 beat/cycle with ready high.
// Backpressure: out_ready low holds the beat and freezes the read address.
module regfile_dump import mips_dbg_pkg::*; #(
  parameter int NREGS = REG_N,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          cclk,
  input  logic          rstb,
  input  logic          start,
  input  logic [AW-1:0] first_reg,
  input  logic [AW-1:0] last_reg,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  regfile_dump_if.master ob
);

  // Beat counter is one bit wider than the index so a full-file dump (NREGS) fits.
  localparam int RW = $clog2(NREGS) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] nxt;
  logic [RW-1:0] remaining;
  logic [AW-1:0] span;
  logic          load;
  logic          accept;

  // Index wrap comes for free from AW-bit arithmetic since NREGS == 2**AW.
  assign span    = last_reg - first_reg;
  assign load    = (state == RUN) && (!ob.out_valid || ob.out_ready);
  assign accept  = ob.out_valid && ob.out_ready;
  assign rd_addr = nxt;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge cclk) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: the last capture moves to DRAIN, its accept moves to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load && (remaining == RW'(1))) state_nxt = DRAIN;
      DRAIN:   if (accept) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read pointer and beat counter: loaded on start, advanced on each capture.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      nxt       <= '0;
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      nxt       <= first_reg;
      remaining <= RW'(span) + RW'(1);
    end else if (load) begin
      nxt       <= nxt + AW'(1);
      remaining <= remaining - RW'(1);
    end
  end

  // Output register: capture the presented read data, hold until accepted.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      ob.out_valid <= 1'b0;
      ob.out_data  <= '0;
      ob.out_index <= '0;
    end else if (load) begin
      ob.out_valid <= 1'b1;
      ob.out_data  <= rd_data;
      ob.out_index <= nxt;
    end else if (accept) begin
      ob.out_valid <= 1'b0;
    end
  end

endmodule
